uart_rx: RTL and testbench

UART receive front end (8N1, LSB first) that deserialises the external serial line into bytes. It presents each byte on a valid/ready holding register that the SRAM command controller drains through `rx_data_out`, `rx_valid` and `rx_ready`. It sits directly upstream of that controller, which gates reception with `rx_enable`.

---
 rtl/uart_pkg.sv | 6 +
 rtl/uart_sync2.sv | 21 ++
 rtl/uart_rx.sv | 118 +++++++++++
 tb/tb_uart_rx.sv | 187 ++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// uart_pkg: shared UART constants and the receiver state encoding.
package uart_pkg;
    localparam int UART_DATA_BITS    = 8;
    localparam int UART_CLKS_PER_BIT = 104;
    typedef enum logic [2:0] {IDLE, START, DATA, STOP, BREAK} uart_rx_state_t;
endpackage

// File: rtl/uart_sync2.sv
// uart_sync2: two-flop synchroniser for an asynchronous single-bit input.
module uart_sync2 #(
    parameter logic RST_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d,
    output logic q
);
    logic meta_q, sync_q;
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= RST_VAL;
            sync_q <= RST_VAL;
        end else begin
            meta_q <= d;
            sync_q <= meta_q;
        end
    end
    assign q = sync_q;
endmodule

// File: rtl/uart_rx.sv
// uart_rx: 8N1 UART receiver feeding a valid/ready holding register.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = UART_CLKS_PER_BIT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       uart_rxd,
    input  logic       rx_enable,
    input  logic       rx_ready,
    output logic [7:0] rx_data_out,
    output logic       rx_valid,
    output logic       frame_err,
    output logic       overrun
);
    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int IW = $clog2(UART_DATA_BITS);
    localparam logic [CW-1:0] HALF_END = CW'(CLKS_PER_BIT / 2 - 1);
    localparam logic [CW-1:0] FULL_END = CW'(CLKS_PER_BIT - 1);
    localparam logic [IW-1:0] LAST_IDX = IW'(UART_DATA_BITS - 1);

    uart_rx_state_t            state_q, state_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic [IW-1:0]             idx_q, idx_d;
    logic [UART_DATA_BITS-1:0] shift_q, shift_d, data_q, data_d;
    logic                      valid_q, valid_d, fe_q, fe_d, ov_q, ov_d;
    logic                      rxs, done, xfer;

    uart_sync2 #(.RST_VAL(1'b1)) u_sync (.clk(clk), .rst(rst), .d(uart_rxd), .q(rxs));

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + CW'(1);
        idx_d   = idx_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = valid_q;
        fe_d    = 1'b0;
        ov_d    = 1'b0;
        done    = 1'b0;
        xfer    = valid_q && rx_ready;
        // Losing the enable mid-frame drops the frame silently.
        if (!rx_enable && state_q != IDLE) begin
            state_d = IDLE;
            cnt_d   = '0;
        end else begin
            case (state_q)
                IDLE: begin
                    cnt_d = '0;
                    idx_d = '0;
                    if (rx_enable && !rxs) state_d = START;
                end
                START: if (cnt_q == HALF_END) begin
                    cnt_d   = '0;
                    idx_d   = '0;
                    state_d = rxs ? IDLE : DATA;
                end
                DATA: if (cnt_q == FULL_END) begin
                    cnt_d          = '0;
                    shift_d[idx_q] = rxs;
                    idx_d          = idx_q + IW'(1);
                    if (idx_q == LAST_IDX) state_d = STOP;
                end
                STOP: if (cnt_q == FULL_END) begin
                    cnt_d   = '0;
                    done    = rxs;
                    fe_d    = !rxs;
                    state_d = rxs ? IDLE : BREAK;
                end
                BREAK: begin
                    cnt_d = '0;
                    if (rxs) state_d = IDLE;
                end
                default: begin
                    cnt_d   = '0;
                    state_d = IDLE;
                end
            endcase
        end
        // A same-cycle drain frees the register for the new byte.
        if (done && (!valid_q || xfer)) begin
            data_d  = shift_q;
            valid_d = 1'b1;
        end else if (done) begin
            ov_d = 1'b1;
        end else if (xfer) begin
            valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            idx_q   <= '0;
            shift_q <= '0;
            data_q  <= '0;
            valid_q <= 1'b0;
            fe_q    <= 1'b0;
            ov_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            idx_q   <= idx_d;
            shift_q <= shift_d;
            data_q  <= data_d;
            valid_q <= valid_d;
            fe_q    <= fe_d;
            ov_q    <= ov_d;
        end
    end

    assign rx_data_out = data_q;
    assign rx_valid    = valid_q;
    assign frame_err   = fe_q;
    assign overrun     = ov_q;
endmodule

// File: tb/tb_uart_rx.sv
// tb_uart_rx: scoreboard bench for uart_rx with directed frames at 8 clocks per bit.
module tb_uart_rx;
    import uart_pkg::*;
    localparam int N = 8;

    logic       clk = 0, rst = 1, uart_rxd = 1, rx_enable = 0, rx_ready = 0;
    logic [7:0] rx_data_out;
    logic       rx_valid, frame_err, overrun;
    int         checks = 0, errors = 0, cyc = 0, fe_cnt = 0, ov_cnt = 0, pres_cyc = -1;
    int         s, f0, o0;
    logic [7:0] exp_q[$];
    logic [7:0] e;
    logic       pv = 0, pr = 0;

    always #5 clk = ~clk;

    uart_rx #(.CLKS_PER_BIT(N)) dut (
        .clk(clk), .rst(rst), .uart_rxd(uart_rxd), .rx_enable(rx_enable), .rx_ready(rx_ready),
        .rx_data_out(rx_data_out), .rx_valid(rx_valid), .frame_err(frame_err), .overrun(overrun)
    );

    always @(posedge clk) cyc <= cyc + 1;

    // Monitor: a byte is presented when rx_valid is high after being low or after a transfer.
    always @(negedge clk) begin
        if (frame_err) fe_cnt++;
        if (overrun) ov_cnt++;
        if (rx_valid && (!pv || pr)) begin
            pres_cyc = cyc;
            checks++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL unexpected_byte got %h expected none", rx_data_out);
            end else begin
                e = exp_q.pop_front();
                if (rx_data_out !== e) begin
                    errors++;
                    $display("FAIL rx_byte got %h expected %h", rx_data_out, e);
                end
            end
        end
        pv = rx_valid;
        pr = rx_ready;
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic idle(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic line(input logic b, input int n);
        uart_rxd = b;
        idle(n);
    endtask

    task automatic send(input logic [7:0] d, input logic stop = 1'b1, input int stop_len = N);
        line(1'b0, N);
        for (int i = 0; i < 8; i++) line(d[i], N);
        line(stop, stop_len);
        uart_rxd = 1'b1;
    endtask

    task automatic drain();
        rx_ready = 1'b1;
        idle(1);
        rx_ready = 1'b0;
        chk("drain_valid", rx_valid, 0);
    endtask

    initial begin
        idle(3);
        chk("rst_valid", rx_valid, 0);
        chk("rst_data", rx_data_out, 0);
        chk("rst_fe", frame_err, 0);
        chk("rst_ov", overrun, 0);
        rst = 0;
        rx_enable = 1;
        idle(2);

        s = cyc;
        exp_q.push_back(8'hA5);
        send(8'hA5);
        chk("a5_latency", pres_cyc - s, 79);
        idle(30);
        chk("a5_hold_valid", rx_valid, 1);
        chk("a5_hold_data", rx_data_out, 8'hA5);
        drain();
        chk("a5_no_fe", fe_cnt, 0);
        chk("a5_no_ov", ov_cnt, 0);

        line(1'b0, 3);
        line(1'b1, 12);
        chk("glitch_state", dut.state_q, IDLE);
        chk("glitch_valid", rx_valid, 0);
        exp_q.push_back(8'h3C);
        send(8'h3C);
        drain();

        f0 = fe_cnt;
        send(8'h55, 1'b0, 20);
        idle(4);
        chk("fe_pulse", fe_cnt - f0, 1);
        chk("fe_valid", rx_valid, 0);
        exp_q.push_back(8'h81);
        send(8'h81);
        drain();

        o0 = ov_cnt;
        exp_q.push_back(8'h11);
        send(8'h11);
        send(8'h22);
        idle(2);
        chk("ov_pulse", ov_cnt - o0, 1);
        chk("ov_data", rx_data_out, 8'h11);
        chk("ov_valid", rx_valid, 1);
        drain();

        o0 = ov_cnt;
        exp_q.push_back(8'h11);
        exp_q.push_back(8'h22);
        send(8'h11);
        fork
            send(8'h22);
            begin
                idle(78);
                rx_ready = 1'b1;
                idle(1);
                rx_ready = 1'b0;
                chk("sim_valid_kept", rx_valid, 1);
            end
        join
        chk("sim_data", rx_data_out, 8'h22);
        chk("sim_no_ov", ov_cnt - o0, 0);
        drain();

        f0 = fe_cnt;
        o0 = ov_cnt;
        fork
            send(8'hF0);
            begin
                idle(34);
                rx_enable = 1'b0;
            end
        join
        idle(4);
        rx_enable = 1'b1;
        chk("abort_valid", rx_valid, 0);
        chk("abort_pulses", (fe_cnt - f0) + (ov_cnt - o0), 0);
        exp_q.push_back(8'h0F);
        send(8'h0F);
        drain();

        exp_q.push_back(8'hAA);
        send(8'hAA);
        chk("pre_rst_valid", rx_valid, 1);
        fork
            send(8'h5A);
            begin
                idle(30);
                #2 rst = 1'b1;
                #1;
                chk("arst_valid", rx_valid, 0);
                chk("arst_data", rx_data_out, 0);
                chk("arst_fe", frame_err, 0);
                chk("arst_ov", overrun, 0);
            end
        join
        rst = 1'b0;
        idle(2);
        exp_q.push_back(8'hC3);
        send(8'hC3);
        drain();

        idle(5);
        chk("queue_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
